// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with load, saturate mode, wrap pulse and sticky ovf
module updown_mod_counter #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_bound;

    // Bound in the current count direction; also drives tc regardless of en.
    assign at_bound = up ? (q_q == MAX) : (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q & ~clr_ovf;
        if (reset) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            q_d = (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            if (at_bound) begin
                // Setting ovf after the clear lets a coincident bound hit win.
                if (sat) begin
                    ovf_d = 1'b1;
                end else begin
                    q_d    = up ? '0 : MAX;
                    wrap_d = 1'b1;
                end
            end else begin
                q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        q_q    <= q_d;
        wrap_q <= wrap_d;
        ovf_q  <= ovf_d;
    end

    assign q    = q_q;
    assign tc   = at_bound;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed and random checks of two counter instances (MAX=7, MAX=5)
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, sat, load, clr_ovf;
    logic [2:0] load_val;
    logic [2:0] q7, q5;
    logic       tc7, tc5, wrap7, wrap5, ovf7, ovf5;

    int n_cmp = 0;
    int n_err = 0;

    int m_q[2];
    int m_wrap[2];
    int m_ovf[2];
    int m_max[2] = '{7, 5};

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(3), .MAX(3'd7)) dut7 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q7), .tc(tc7), .wrap(wrap7), .ovf(ovf7)
    );

    updown_mod_counter #(.WIDTH(3), .MAX(3'd5)) dut5 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q5), .tc(tc5), .wrap(wrap5), .ovf(ovf5)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: counting is arithmetic modulo MAX+1; a step off a bound is a wrap or, in sat mode, a hold.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  m;
            bit  hit;
            m = m_max[i];
            if (reset) begin
                m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (clr_ovf) m_ovf[i] = 0;
                if (load) begin
                    m_q[i] = (int'(load_val) > m) ? m : int'(load_val);
                end else if (en) begin
                    hit = up ? (m_q[i] == m) : (m_q[i] == 0);
                    if (hit && sat) begin
                        m_ovf[i] = 1;
                    end else begin
                        m_q[i]    = (m_q[i] + (up ? 1 : m)) % (m + 1);
                        m_wrap[i] = hit ? 1 : 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_tc(input int i);
        return up ? int'(m_q[i] == m_max[i]) : int'(m_q[i] == 0);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " q7"},    int'(q7),    m_q[0]);
        chk({tag, " wrap7"}, int'(wrap7), m_wrap[0]);
        chk({tag, " ovf7"},  int'(ovf7),  m_ovf[0]);
        chk({tag, " tc7"},   int'(tc7),   exp_tc(0));
        chk({tag, " q5"},    int'(q5),    m_q[1]);
        chk({tag, " wrap5"}, int'(wrap5), m_wrap[1]);
        chk({tag, " ovf5"},  int'(ovf5),  m_ovf[1]);
        chk({tag, " tc5"},   int'(tc5),   exp_tc(1));
    endtask

    initial begin
        m_q = '{0, 0}; m_wrap = '{0, 0}; m_ovf = '{0, 0};
        reset = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b1;
        load_val = 3'd4; clr_ovf = 1'b0;

        // Reset dominates load and en.
        tick();
        check_all("reset");
        chk("reset tc7 up=1", int'(tc7), 0);
        up = 1'b0;
        #1;
        chk("reset tc7 up=0", int'(tc7), 1);
        chk("reset tc5 up=0", int'(tc5), 1);

        // Up wrap over 9 edges.
        reset = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_all("upwrap");
        end
        chk("upwrap final q7", int'(q7), 1);

        // Down count from 0 through the MAX=5 modulus.
        reset = 1'b1;
        tick();
        reset = 1'b0; up = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_all("down");
        end
        chk("down final q5", int'(q5), 5);

        // Saturate at MAX, then clear ovf.
        en = 1'b0; load = 1'b1; load_val = 3'd6;
        tick();
        check_all("satload");
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all("sat");
        end
        chk("sat hold q7", int'(q7), 7);
        chk("sat ovf7", int'(ovf7), 1);
        // Clear coincident with another bound hit keeps ovf set.
        clr_ovf = 1'b1;
        tick();
        check_all("clr_vs_hit");
        en = 1'b0;
        tick();
        check_all("clr");
        chk("clr ovf7", int'(ovf7), 0);
        clr_ovf = 1'b0;

        // Load beats en; reset beats load.
        load = 1'b1; load_val = 3'd3; en = 1'b1; up = 1'b1; sat = 1'b0;
        tick();
        check_all("load_pri");
        chk("load_pri q7", int'(q7), 3);
        reset = 1'b1;
        tick();
        check_all("reset_pri");
        reset = 1'b0;

        // Load clamp on MAX=5.
        load_val = 3'd7; en = 1'b0;
        tick();
        check_all("clamp");
        chk("clamp q5", int'(q5), 5);
        chk("clamp tc5", int'(tc5), 1);

        // Reset on the edge after a wrap cancels the pulse.
        load = 1'b0; en = 1'b1;
        tick();
        check_all("prewrap");
        reset = 1'b1;
        tick();
        check_all("midwrap_reset");
        reset = 1'b0;
        tick();
        check_all("resume");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1);
            sat      = $urandom_range(0, 1);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            load_val = 3'($urandom_range(0, 7));
            tick();
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
